// File: rtl/ghost_pkg.sv
// Shared encodings for the ghost subsystem: output mode codes and the
// scheduler's phase state, used by the scheduler, ghost movers and renderer.
package ghost_pkg;

   // Mode codes presented to ghost movers and the renderer (2'b11 unused)
   localparam logic [1:0] MODE_SCATTER = 2'b00;
   localparam logic [1:0] MODE_CHASE   = 2'b01;
   localparam logic [1:0] MODE_FRIGHT  = 2'b10;

   typedef enum logic [1:0] {
      ST_SCATTER = 2'd0,
      ST_CHASE   = 2'd1,
      ST_FRIGHT  = 2'd2
   } ghost_state_t;

   // Map an underlying scatter/chase mode back onto its phase state
   function automatic ghost_state_t mode_to_state(input logic [1:0] m);
      if (m == MODE_CHASE) begin
         return ST_CHASE;
      end
      return ST_SCATTER;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides the system clock into a one-cycle movement tick every TICK_DIV
// cycles. The count holds while paused and restarts on a round restart.
// tick_next exposes the value move_tick takes after the coming edge so a
// parent can register strobes that line up with move_tick.
module tick_divider #(
   parameter int TICK_DIV = 500000
) (
   input  logic move_clk,
   input  logic reset_n,
   input  logic resetW,
   input  logic pause,
   output logic move_tick,
   output logic tick_next
);

   localparam int CW = $clog2(TICK_DIV - 1) + 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic          tick_reg;

   // Next count; the tick is high while the count sits at its final value
   always_comb begin
      count_next = count_reg;
      tick_next  = 1'b0;
      if (resetW) begin
         count_next = '0;
      end else if (!pause) begin
         count_next = (count_reg == LAST) ? '0 : count_reg + CW'(1);
         tick_next  = (count_next == LAST);
      end
   end

   // Count and tick registers
   always_ff @(posedge move_clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
         tick_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         tick_reg  <= tick_next;
      end
   end

   assign move_tick = tick_reg;

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost sequencer: movement tick generation, scatter/chase phase
// schedule, frightened mode, staggered house release and per-ghost step
// strobes. All outputs are registered.
module ghost_mode_scheduler
   import ghost_pkg::*;
#(
   parameter int NUM_GHOSTS    = 4,
   parameter int TICK_DIV      = 500000,
   parameter int SCATTER_TICKS = 70,
   parameter int CHASE_TICKS   = 200,
   parameter int NUM_PHASES    = 7,
   parameter int FRIGHT_TICKS  = 60,
   parameter int BLINK_TICKS   = 15,
   parameter int RELEASE_GAP   = 30
) (
   input  logic                  move_clk,
   input  logic                  reset_n,
   input  logic                  resetW,
   input  logic                  pause,
   input  logic                  pellet_eaten,
   output logic                  move_tick,
   output logic [1:0]            mode,
   output logic                  reverse,
   output logic                  fright_blink,
   output logic [NUM_GHOSTS-1:0] released,
   output logic [NUM_GHOSTS-1:0] step_en
);

   localparam int PH_MAX  = ((SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS) - 1;
   localparam int PW      = $clog2(PH_MAX) + 1;
   localparam int IW      = $clog2(NUM_PHASES - 1) + 1;
   localparam int FW      = $clog2(FRIGHT_TICKS) + 1;
   localparam int REL_MAX = (NUM_GHOSTS - 1) * RELEASE_GAP;
   localparam int RW      = $clog2(REL_MAX) + 1;

   localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_PHASES - 1);
   localparam logic [PW-1:0] SCATTER_LAST = PW'(SCATTER_TICKS - 1);
   localparam logic [PW-1:0] CHASE_LAST   = PW'(CHASE_TICKS - 1);
   localparam logic [FW-1:0] FRIGHT_LOAD  = FW'(FRIGHT_TICKS);
   localparam logic [FW-1:0] BLINK_LEVEL  = FW'(BLINK_TICKS);
   localparam logic [RW-1:0] REL_LIMIT    = RW'(REL_MAX);

   // Underlying mode of a phase: odd phases chase, and so does the final one
   function automatic logic [1:0] phase_mode(input logic [IW-1:0] idx);
      if ((idx == LAST_IDX) || idx[0]) begin
         return MODE_CHASE;
      end
      return MODE_SCATTER;
   endfunction

   ghost_state_t          state_reg,        state_next;
   logic [1:0]            saved_mode_reg,   saved_mode_next;
   logic [IW-1:0]         phase_idx_reg,    phase_idx_next;
   logic [PW-1:0]         phase_timer_reg,  phase_timer_next;
   logic [FW-1:0]         fright_timer_reg, fright_timer_next;
   logic                  parity_reg,       parity_next;
   logic [RW-1:0]         rel_timer_reg,    rel_timer_next;
   logic [1:0]            mode_reg,         mode_next;
   logic                  reverse_reg,      reverse_next;
   logic                  blink_reg,        blink_next;
   logic [NUM_GHOSTS-1:0] released_reg,     released_next;
   logic [NUM_GHOSTS-1:0] step_en_reg,      step_en_next;

   logic tick_next;
   logic advance;
   logic pellet;

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .move_clk  (move_clk),
      .reset_n   (reset_n),
      .resetW    (resetW),
      .pause     (pause),
      .move_tick (move_tick),
      .tick_next (tick_next)
   );

   // A pause freezes every timer and swallows pellet events
   assign advance = move_tick & ~pause;
   assign pellet  = pellet_eaten & ~pause;

   // Each ghost leaves the house once the release timer reaches its slot
   generate
      for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_release
         assign released_next[gi] = (~resetW & released_reg[gi])
                                  | (rel_timer_next >= RW'(gi * RELEASE_GAP));
      end
   endgenerate

   // Phase schedule, frightened mode and strobe generation
   always_comb begin
      state_next        = state_reg;
      saved_mode_next   = saved_mode_reg;
      phase_idx_next    = phase_idx_reg;
      phase_timer_next  = phase_timer_reg;
      fright_timer_next = fright_timer_reg;
      parity_next       = parity_reg;
      rel_timer_next    = rel_timer_reg;
      mode_next         = mode_reg;
      reverse_next      = 1'b0;
      blink_next        = 1'b0;
      step_en_next      = '0;
      if (resetW) begin
         state_next        = ST_SCATTER;
         saved_mode_next   = MODE_SCATTER;
         phase_idx_next    = '0;
         phase_timer_next  = '0;
         fright_timer_next = '0;
         parity_next       = 1'b0;
         rel_timer_next    = '0;
         mode_next         = MODE_SCATTER;
      end else begin
         if (advance && (rel_timer_reg != REL_LIMIT)) begin
            rel_timer_next = rel_timer_reg + RW'(1);
         end
         if (state_reg != ST_FRIGHT) begin
            // Phase advance lands in saved_mode before a coincident pellet
            if (advance && (phase_idx_reg != LAST_IDX)) begin
               if (phase_timer_reg == (phase_idx_reg[0] ? CHASE_LAST : SCATTER_LAST)) begin
                  phase_idx_next   = phase_idx_reg + IW'(1);
                  phase_timer_next = '0;
                  saved_mode_next  = phase_mode(phase_idx_next);
               end else begin
                  phase_timer_next = phase_timer_reg + PW'(1);
               end
            end
            if (pellet) begin
               state_next        = ST_FRIGHT;
               fright_timer_next = FRIGHT_LOAD;
               parity_next       = 1'b0;
            end else begin
               state_next = mode_to_state(saved_mode_next);
            end
         end else begin
            if (advance) begin
               parity_next = ~parity_reg;
            end
            if (pellet) begin
               fright_timer_next = FRIGHT_LOAD;
            end else if (advance) begin
               fright_timer_next = fright_timer_reg - FW'(1);
               if (fright_timer_next == '0) begin
                  state_next = mode_to_state(saved_mode_reg);
               end
            end
         end
         mode_next    = (state_next == ST_FRIGHT) ? MODE_FRIGHT : saved_mode_next;
         reverse_next = (mode_next != mode_reg);
         blink_next   = (state_next == ST_FRIGHT) && (fright_timer_next <= BLINK_LEVEL);
         // Strobe is loaded alongside the tick so both appear in the same cycle
         if (tick_next && ((state_reg != ST_FRIGHT) || parity_reg)) begin
            step_en_next = released_reg;
         end
      end
   end

   // State and output registers
   always_ff @(posedge move_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= ST_SCATTER;
         saved_mode_reg   <= MODE_SCATTER;
         phase_idx_reg    <= '0;
         phase_timer_reg  <= '0;
         fright_timer_reg <= '0;
         parity_reg       <= 1'b0;
         rel_timer_reg    <= '0;
         mode_reg         <= MODE_SCATTER;
         reverse_reg      <= 1'b0;
         blink_reg        <= 1'b0;
         released_reg     <= NUM_GHOSTS'(1);
         step_en_reg      <= '0;
      end else begin
         state_reg        <= state_next;
         saved_mode_reg   <= saved_mode_next;
         phase_idx_reg    <= phase_idx_next;
         phase_timer_reg  <= phase_timer_next;
         fright_timer_reg <= fright_timer_next;
         parity_reg       <= parity_next;
         rel_timer_reg    <= rel_timer_next;
         mode_reg         <= mode_next;
         reverse_reg      <= reverse_next;
         blink_reg        <= blink_next;
         released_reg     <= released_next;
         step_en_reg      <= step_en_next;
      end
   end

   assign mode         = mode_reg;
   assign reverse      = reverse_reg;
   assign fright_blink = blink_reg;
   assign released     = released_reg;
   assign step_en      = step_en_reg;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Scoreboard bench for ghost_mode_scheduler: a tick-level behavioural model
// predicts every cycle's outputs into a queue; a monitor pops and compares.
module tb_ghost_mode_scheduler;

   localparam int N   = 4;
   localparam int TD  = 4;
   localparam int ST  = 3;
   localparam int CT  = 5;
   localparam int NP  = 3;
   localparam int FT  = 4;
   localparam int BT  = 2;
   localparam int GAP = 2;

   logic         move_clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         resetW = 1'b0;
   logic         pause = 1'b0;
   logic         pellet_eaten = 1'b0;
   logic         move_tick;
   logic [1:0]   mode;
   logic         reverse;
   logic         fright_blink;
   logic [N-1:0] released;
   logic [N-1:0] step_en;

   ghost_mode_scheduler #(
      .NUM_GHOSTS    (N),
      .TICK_DIV      (TD),
      .SCATTER_TICKS (ST),
      .CHASE_TICKS   (CT),
      .NUM_PHASES    (NP),
      .FRIGHT_TICKS  (FT),
      .BLINK_TICKS   (BT),
      .RELEASE_GAP   (GAP)
   ) dut (
      .move_clk     (move_clk),
      .reset_n      (reset_n),
      .resetW       (resetW),
      .pause        (pause),
      .pellet_eaten (pellet_eaten),
      .move_tick    (move_tick),
      .mode         (mode),
      .reverse      (reverse),
      .fright_blink (fright_blink),
      .released     (released),
      .step_en      (step_en)
   );

   always #5 move_clk = ~move_clk;

   typedef struct {
      logic         tick;
      logic [1:0]   mode;
      logic         rev;
      logic         blink;
      logic [N-1:0] rel;
      logic [N-1:0] step;
   } exp_t;

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   bit   checking = 0;

   // Reference model: spec-level quantities kept as plain integers
   int           m_div;      // clock cycles into the current tick period
   bit           m_tick;     // tick visible in the current cycle
   int           m_phase;    // current schedule phase
   int           m_elapsed;  // ticks spent in the current phase
   bit           m_fright;
   int           m_fleft;    // frightened ticks remaining
   bit           m_half;     // frightened ghosts move on every other tick
   int           m_ticks;    // ticks since round start (saturating)
   logic [1:0]   m_mode;
   logic         m_rev;
   logic         m_blink;
   logic [N-1:0] m_step;

   function automatic int phase_len(input int p);
      return (p % 2 == 1) ? CT : ST;
   endfunction

   function automatic logic [1:0] mode_of(input int p);
      return ((p == NP - 1) || (p % 2 == 1)) ? 2'b01 : 2'b00;
   endfunction

   function automatic logic [N-1:0] released_of(input int t);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (t >= i * GAP) r[i] = 1'b1;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_div = 0; m_tick = 0; m_phase = 0; m_elapsed = 0;
      m_fright = 0; m_fleft = 0; m_half = 0; m_ticks = 0;
      m_mode = 2'b00; m_rev = 0; m_blink = 0; m_step = '0;
   endtask

   // Advance the model across one clock edge with the given inputs
   task automatic model_step(input bit p, input bit pe, input bit rw);
      bit           adv;
      bit           pel;
      bit           fr_before;
      bit           half_before;
      logic [1:0]   old_mode;
      logic [N-1:0] rel_before;
      if (rw) begin
         model_reset();
         return;
      end
      adv         = m_tick && !p;
      pel         = pe && !p;
      fr_before   = m_fright;
      half_before = m_half;
      old_mode    = m_mode;
      rel_before  = released_of(m_ticks);
      if (!p) begin
         m_div  = (m_div + 1) % TD;
         m_tick = (m_div == TD - 1);
      end else begin
         m_tick = 0;
      end
      m_step = (m_tick && (!fr_before || half_before)) ? rel_before : '0;
      if (adv && m_ticks < (N - 1) * GAP) m_ticks++;
      if (!m_fright) begin
         if (adv && m_phase < NP - 1) begin
            m_elapsed++;
            if (m_elapsed == phase_len(m_phase)) begin
               m_phase++;
               m_elapsed = 0;
            end
         end
         if (pel) begin
            m_fright = 1; m_fleft = FT; m_half = 0;
         end
      end else begin
         if (adv) m_half = !m_half;
         if (pel) m_fleft = FT;
         else if (adv) begin
            m_fleft--;
            if (m_fleft == 0) m_fright = 0;
         end
      end
      m_mode  = m_fright ? 2'b10 : mode_of(m_phase);
      m_rev   = (m_mode != old_mode);
      m_blink = m_fright && (m_fleft <= BT);
   endtask

   task automatic push_exp();
      exp_t e;
      e.tick = m_tick; e.mode = m_mode; e.rev = m_rev; e.blink = m_blink;
      e.rel = released_of(m_ticks); e.step = m_step;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1: apply inputs, predict the next cycle, wait an edge
   task automatic drive_cycle(input bit p, input bit pe, input bit rw);
      pause = p; pellet_eaten = pe; resetW = rw;
      model_step(p, pe, rw);
      push_exp();
      @(posedge move_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive_cycle(0, 0, 0);
   endtask

   task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
      end
   endtask

   task automatic bound_chk(input string name, input bit ok);
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL %s: wait bound expired, got 0 expected 1", name);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle
   initial begin
      int   cyc;
      int   ticks;
      exp_t e;
      cyc = 0; ticks = 0;
      forever begin
         @(negedge move_clk);
         if (checking) begin
            if (exp_q.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL scoreboard cycle %0d: got empty queue expected entry", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("move_tick",    cyc, 32'(move_tick),    32'(e.tick));
               chk("mode",         cyc, 32'(mode),         32'(e.mode));
               chk("reverse",      cyc, 32'(reverse),      32'(e.rev));
               chk("fright_blink", cyc, 32'(fright_blink), 32'(e.blink));
               chk("released",     cyc, 32'(released),     32'(e.rel));
               chk("step_en",      cyc, 32'(step_en),      32'(e.step));
               if (move_tick || reverse) begin
                  if (move_tick) ticks++;
                  $display("cycle %0d tick %0d: tick=%b mode=%b rev=%b blink=%b released=%b step_en=%b",
                           cyc, ticks, move_tick, mode, reverse, fright_blink, released, step_en);
               end
            end
            cyc++;
         end
      end
   end

   // Stimulus: directed scenarios then randomized traffic
   initial begin
      bit pz;
      model_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge move_clk);
      #1;
      push_exp();          // reset state for the current cycle
      checking = 1;
      reset_n = 1'b1;

      // Free run: release stagger and the full phase schedule
      idle(60);

      // Pellet one tick into scatter, then let frightened mode expire
      drive_cycle(0, 0, 1);
      for (int k = 0; k < 200 && !(m_phase == 0 && m_elapsed == 1 && !m_tick); k++) drive_cycle(0, 0, 0);
      bound_chk("wait_scatter_tick1", m_phase == 0 && m_elapsed == 1 && !m_tick);
      drive_cycle(0, 1, 0);
      idle(30);

      // Second pellet late in frightened mode reloads the timer
      drive_cycle(0, 0, 1);
      for (int k = 0; k < 200 && !(m_phase == 0 && m_elapsed == 1 && !m_tick); k++) drive_cycle(0, 0, 0);
      drive_cycle(0, 1, 0);
      for (int k = 0; k < 200 && !(m_fright && m_fleft == 1 && !m_tick); k++) drive_cycle(0, 0, 0);
      bound_chk("wait_fright_tick3", m_fright && m_fleft == 1 && !m_tick);
      drive_cycle(0, 1, 0);
      idle(30);

      // Pellet coincident with scatter expiry
      drive_cycle(0, 0, 1);
      for (int k = 0; k < 200 && !(m_tick && !m_fright && m_phase == 0 && m_elapsed == ST - 1); k++) drive_cycle(0, 0, 0);
      bound_chk("wait_scatter_expiry", m_tick && !m_fright && m_phase == 0 && m_elapsed == ST - 1);
      drive_cycle(0, 1, 0);
      idle(30);

      // resetW in the middle of frightened mode
      drive_cycle(0, 1, 0);
      idle(6);
      drive_cycle(0, 0, 1);
      idle(3);

      // Pause for 10 cycles with an ignored pellet inside
      for (int k = 0; k < 10; k++) drive_cycle(1, (k == 4), 0);
      idle(20);

      // Randomized traffic
      pz = 0;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(19) == 0) pz = !pz;
         drive_cycle(pz, ($urandom_range(29) == 0), ($urandom_range(399) == 0));
      end
      idle(40);

      // Let the monitor drain the final record, then stop per-cycle checks
      #6;
      checking = 0;
      bound_chk("queue_drained", exp_q.size() == 0);

      // Asynchronous reset between clock edges
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_mode",     -1, 32'(mode),         32'd0);
      chk("async_tick",     -1, 32'(move_tick),    32'd0);
      chk("async_reverse",  -1, 32'(reverse),      32'd0);
      chk("async_blink",    -1, 32'(fright_blink), 32'd0);
      chk("async_released", -1, 32'(released),     32'd1);
      chk("async_step_en",  -1, 32'(step_en),      32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
